shared_reg_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a single shared W-bit D-flip-flop register that N requesters write into.
- Grants one requester at a time and loads that requester's data into the shared register on every granted cycle.
- Bounds each ownership to MAX_HOLD writes when other requesters are waiting.
- Sits between the requester-side logic and the shared register, which it contains.

---
 rtl/shared_reg_arbiter.sv | 151 +++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter and sequencer for one shared W-bit register
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [W-1:0]         q,
    output logic                 q_upd,
    output logic                 busy
);

    localparam int IDW = $clog2(N);
    localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [W-1:0]   q_q, q_d;
    logic           q_upd_q, q_upd_d;

    logic [N-1:0]   others;
    logic [IDW-1:0] owner_next;
    logic [IDW-1:0] nxt;

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] idx);
        return (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First set bit of mask scanning upward from start, wrapping at N.
    function automatic logic [IDW-1:0] sel(input logic [IDW-1:0] start, input logic [N-1:0] mask);
        logic [IDW-1:0] r;
        logic           found;
        int             idx;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && mask[idx]) begin
                r     = IDW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
            q_q      <= '0;
            q_upd_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            q_q      <= q_d;
            q_upd_q  <= q_upd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        q_d        = q_q;
        q_upd_d    = 1'b0;
        nxt        = '0;
        others     = req & ~onehot(gnt_id_q);
        owner_next = inc_mod(gnt_id_q);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    nxt      = sel(ptr_q, req);
                    gnt_d    = onehot(nxt);
                    gnt_id_d = nxt;
                    hold_d   = '0;
                    state_d  = OWN;
                end
            end
            OWN: begin
                if (req[gnt_id_q]) begin
                    q_d     = wdata[int'(gnt_id_q)*W +: W];
                    q_upd_d = 1'b1;
                    // Preempt only once the owner has used its full quota and someone is waiting.
                    if (hold_q == HOLD_LAST && |others) begin
                        nxt      = sel(owner_next, others);
                        gnt_d    = onehot(nxt);
                        gnt_id_d = nxt;
                        hold_d   = '0;
                        ptr_d    = owner_next;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    ptr_d = owner_next;
                    if (|others) begin
                        nxt      = sel(owner_next, req);
                        gnt_d    = onehot(nxt);
                        gnt_id_d = nxt;
                        hold_d   = '0;
                    end else begin
                        gnt_d   = '0;
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt    = gnt_q;
        gnt_id = gnt_id_q;
        q      = q_q;
        q_upd  = q_upd_q;
        busy   = |gnt_q;
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed-vector bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [7:0]  q;
    logic        q_upd;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .q      (q),
        .q_upd  (q_upd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = 32'h44332211;
        for (int e = 0; e < 2; e++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0000 || q !== 8'h00 || q_upd !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
                errors++;
                $display("FAIL reset edge%0d: gnt=%b q=%h q_upd=%b busy=%b gnt_id=%0d, want 0000/00/0/0/0",
                         e, gnt, q, q_upd, busy, gnt_id);
            end
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        logic [3:0] exp_gnt;
        logic [7:0] exp_q;
        logic       exp_upd;
        do_reset();
        wdata = 32'h000000A5;
        req   = 4'b0001;
        for (int e = 1; e <= 4; e++) begin
            if (e == 4) req = 4'b0000;
            tick();
            exp_gnt = (e <= 3) ? 4'b0001 : 4'b0000;
            exp_q   = (e >= 2) ? 8'hA5 : 8'h00;
            exp_upd = (e == 2 || e == 3);
            vectors++;
            if (gnt !== exp_gnt || q !== exp_q || q_upd !== exp_upd || busy !== (e <= 3) || gnt_id !== 2'd0) begin
                errors++;
                $display("FAIL single edge%0d: gnt=%b q=%h q_upd=%b busy=%b gnt_id=%0d, want %b/%h/%b/%b/0",
                         e, gnt, q, q_upd, busy, gnt_id, exp_gnt, exp_q, exp_upd, (e <= 3));
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        logic [7:0] exp_q;
        logic [7:0] slice [4];
        slice[0] = 8'h11; slice[1] = 8'h22; slice[2] = 8'h33; slice[3] = 8'h44;
        do_reset();
        wdata = 32'h44332211;
        req   = 4'b1111;
        for (int e = 1; e <= 17; e++) begin
            tick();
            exp_gnt = 4'b0001 << (((e - 1) / 4) % 4);
            exp_q   = (e >= 2) ? slice[((e - 2) / 4) % 4] : 8'h00;
            vectors++;
            if (gnt !== exp_gnt || q !== exp_q || q_upd !== (e >= 2) || busy !== 1'b1) begin
                errors++;
                $display("FAIL contention edge%0d: gnt=%b q=%h q_upd=%b busy=%b, want %b/%h/%b/1",
                         e, gnt, q, q_upd, busy, exp_gnt, exp_q, (e >= 2));
            end
        end
    endtask

    task automatic test_lone_owner();
        do_reset();
        wdata = 32'h005C0000;
        req   = 4'b0100;
        for (int e = 1; e <= 10; e++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1 || q_upd !== (e >= 2) ||
                q !== ((e >= 2) ? 8'h5C : 8'h00)) begin
                errors++;
                $display("FAIL lone edge%0d: gnt=%b gnt_id=%0d busy=%b q=%h q_upd=%b, want 0100/2/1/%h/%b",
                         e, gnt, gnt_id, busy, q, q_upd, ((e >= 2) ? 8'h5C : 8'h00), (e >= 2));
            end
        end
    endtask

    task automatic test_early_release();
        logic [3:0] exp_gnt [5];
        logic [7:0] exp_q   [5];
        logic       exp_upd [5];
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
        exp_q   = '{8'h00,   8'hAA,   8'hAA,   8'hAA,   8'hDD};
        exp_upd = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
        do_reset();
        wdata = 32'hDDCCBBAA;
        req   = 4'b1001;
        for (int e = 0; e < 5; e++) begin
            if (e == 3) req = 4'b1000;
            tick();
            vectors++;
            if (gnt !== exp_gnt[e] || q !== exp_q[e] || q_upd !== exp_upd[e]) begin
                errors++;
                $display("FAIL early_release edge%0d: gnt=%b q=%h q_upd=%b, want %b/%h/%b",
                         e + 1, gnt, q, q_upd, exp_gnt[e], exp_q[e], exp_upd[e]);
            end
        end
        vectors++;
        if (gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL early_release gnt_id: got %0d want 3", gnt_id);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        wdata = 32'h00770000;
        req   = 4'b0100;
        for (int e = 0; e < 3; e++) tick();
        vectors++;
        if (gnt !== 4'b0100 || q !== 8'h77 || q_upd !== 1'b1) begin
            errors++;
            $display("FAIL midburst pre: gnt=%b q=%h q_upd=%b, want 0100/77/1", gnt, q, q_upd);
        end
        rst = 1'b1;
        req = 4'b1111;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || q !== 8'h00 || q_upd !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midburst rst: gnt=%b q=%h q_upd=%b busy=%b gnt_id=%0d, want 0000/00/0/0/0",
                     gnt, q, q_upd, busy, gnt_id);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || q_upd !== 1'b0) begin
            errors++;
            $display("FAIL midburst regrant: gnt=%b gnt_id=%0d q_upd=%b, want 0001/0/0", gnt, gnt_id, q_upd);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        test_reset();
        test_single();
        test_contention();
        test_lone_owner();
        test_early_release();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
